// File: rtl/hpi_otg_responder.sv
// Device-side HPI responder emulating the EZ-OTG host port: four registers, word RAM, mailbox handshake.
// Optional HPI_INTR_EN adds a registered OTG_INT output mirroring mbx_out_full one cycle late.
module hpi_otg_responder #(
  parameter int MEM_AW = 12
) (
  input  logic        Clk,
  input  logic        Reset,
  inout  wire  [15:0] OTG_DATA,
  input  logic [1:0]  OTG_ADDR,
  input  logic        OTG_RD_N,
  input  logic        OTG_WR_N,
  input  logic        OTG_CS_N,
  input  logic        OTG_RST_N,
  output logic [15:0] mbx_in_data,
  output logic        mbx_in_valid,
  input  logic        mbx_in_ack,
  input  logic [15:0] mbx_out_data,
  input  logic        mbx_out_wr,
  output logic        mbx_out_full
`ifdef HPI_INTR_EN
  ,
  output logic        OTG_INT
`endif
);

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_MAILBOX = 2'd1;
  localparam logic [1:0] REG_ADDRESS = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  logic [15:0] mem [0:(1<<MEM_AW)-1];

  logic [15:0] addr_q;
  logic [15:0] rd_data_q;
  logic        oe_q;
  logic [15:0] mbx_out_q;
  logic        overrun;
  logic        prev_rd;
  logic        prev_wr;
  logic        rst_hold_q;

  logic              soft_rst;
  logic              access_ok;
  logic              wr_start;
  logic              rd_start;
  logic [MEM_AW-1:0] mem_idx;

  // After any reset, strobes still low from an aborted access must rise before a new access counts.
  assign soft_rst  = Reset | ~OTG_RST_N;
  assign access_ok = ~soft_rst & ~rst_hold_q & ~OTG_CS_N;
  assign wr_start  = access_ok & ~OTG_WR_N & prev_wr;
  assign rd_start  = access_ok & ~OTG_RD_N & prev_rd & OTG_WR_N;
  assign mem_idx   = addr_q[MEM_AW:1];

  assign OTG_DATA = oe_q ? rd_data_q : 16'bz;

  always_ff @(posedge Clk) begin
    if (wr_start && OTG_ADDR == REG_DATA)
      mem[mem_idx] <= OTG_DATA;
  end

  always_ff @(posedge Clk) begin
    if (soft_rst) begin
      addr_q       <= 16'h0000;
      rd_data_q    <= 16'h0000;
      oe_q         <= 1'b0;
      mbx_in_data  <= 16'h0000;
      mbx_in_valid <= 1'b0;
      mbx_out_q    <= 16'h0000;
      mbx_out_full <= 1'b0;
      overrun      <= 1'b0;
      prev_rd      <= 1'b1;
      prev_wr      <= 1'b1;
      rst_hold_q   <= 1'b1;
    end else begin
      prev_rd <= OTG_RD_N;
      prev_wr <= OTG_WR_N;
      if (OTG_RD_N && OTG_WR_N)
        rst_hold_q <= 1'b0;
      oe_q <= ~OTG_CS_N & ~OTG_RD_N & OTG_WR_N;

      // A host mailbox write beats a same-cycle ack from local logic.
      if (wr_start && OTG_ADDR == REG_MAILBOX) begin
        mbx_in_data  <= OTG_DATA;
        mbx_in_valid <= 1'b1;
        if (mbx_in_valid && !mbx_in_ack)
          overrun <= 1'b1;
      end else if (mbx_in_ack) begin
        mbx_in_valid <= 1'b0;
      end

      if (mbx_out_wr) begin
        mbx_out_q    <= mbx_out_data;
        mbx_out_full <= 1'b1;
      end else if (rd_start && OTG_ADDR == REG_MAILBOX) begin
        mbx_out_full <= 1'b0;
      end

      if (wr_start) begin
        case (OTG_ADDR)
          REG_DATA:    addr_q <= addr_q + 16'd2;
          REG_ADDRESS: addr_q <= OTG_DATA;
          default:     ;
        endcase
      end

      if (rd_start) begin
        case (OTG_ADDR)
          REG_DATA: begin
            rd_data_q <= mem[mem_idx];
            addr_q    <= addr_q + 16'd2;
          end
          REG_MAILBOX: rd_data_q <= mbx_out_q;
          REG_ADDRESS: rd_data_q <= addr_q;
          REG_STATUS: begin
            rd_data_q <= {13'b0, overrun, mbx_in_valid, mbx_out_full};
            overrun   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef HPI_INTR_EN
  always_ff @(posedge Clk) begin
    if (soft_rst)
      OTG_INT <= 1'b0;
    else
      OTG_INT <= mbx_out_full;
  end
`endif

endmodule

// File: tb/tb_hpi_otg_responder.sv
// Scoreboard bench for hpi_otg_responder: host reads queue expected words, a negedge monitor checks the bus.
module tb_hpi_otg_responder;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MBX  = 2'd1;
  localparam logic [1:0] A_ADDR = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;
  localparam logic [15:0] UNDRIVEN = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  tri1  [15:0] otg_data;
  logic [1:0]  addr = 2'd0;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        cs_n = 1'b1;
  logic        rst_n = 1'b1;
  logic [15:0] mbx_in_data;
  logic        mbx_in_valid;
  logic        mbx_in_ack = 1'b0;
  logic [15:0] mbx_out_data = 16'h0000;
  logic        mbx_out_wr = 1'b0;
  logic        mbx_out_full;
  logic        host_oe = 1'b0;
  logic [15:0] host_wdata = 16'h0000;
`ifdef HPI_INTR_EN
  logic        otg_int;
`endif

  int assert_cnt = 0;
  int fail_cnt = 0;
  logic [15:0] exp_q[$];
  int rd_low_cycles = 0;

  assign otg_data = host_oe ? host_wdata : 16'bz;

  always #5 clk = ~clk;

  hpi_otg_responder #(.MEM_AW(12)) dut (
    .Clk          (clk),
    .Reset        (reset),
    .OTG_DATA     (otg_data),
    .OTG_ADDR     (addr),
    .OTG_RD_N     (rd_n),
    .OTG_WR_N     (wr_n),
    .OTG_CS_N     (cs_n),
    .OTG_RST_N    (rst_n),
    .mbx_in_data  (mbx_in_data),
    .mbx_in_valid (mbx_in_valid),
    .mbx_in_ack   (mbx_in_ack),
    .mbx_out_data (mbx_out_data),
    .mbx_out_wr   (mbx_out_wr),
    .mbx_out_full (mbx_out_full)
`ifdef HPI_INTR_EN
    ,
    .OTG_INT      (otg_int)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Read data is on the bus from the second cycle of a qualified read strobe.
  always @(negedge clk) begin
    if (!cs_n && !rd_n && wr_n)
      rd_low_cycles++;
    else
      rd_low_cycles = 0;
    if (rd_low_cycles == 2) begin
      if (exp_q.size() == 0)
        checkOutput("unexpected read", {16'h0, otg_data}, 32'hDEAD_BEEF);
      else
        checkOutput("bus read", {16'h0, otg_data}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic hostWrite(input logic [1:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    addr = a; host_wdata = d; host_oe = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    cs_n = 1'b1; wr_n = 1'b1; host_oe = 1'b0;
  endtask

  task automatic hostRead(input logic [1:0] a, input logic [15:0] exp);
    @(posedge clk); #1;
    addr = a; cs_n = 1'b0; rd_n = 1'b0;
    exp_q.push_back(exp);
    repeat (2) @(posedge clk);
    #1;
    cs_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic postOut(input logic [15:0] d);
    @(posedge clk); #1;
    mbx_out_data = d; mbx_out_wr = 1'b1;
    @(posedge clk); #1;
    mbx_out_wr = 1'b0;
  endtask

  task automatic applyStimulus();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset mbx_in_valid", {31'h0, mbx_in_valid}, 32'h0);
    checkOutput("reset mbx_in_data", {16'h0, mbx_in_data}, 32'h0);
    checkOutput("reset mbx_out_full", {31'h0, mbx_out_full}, 32'h0);
    checkOutput("reset bus idle", {16'h0, otg_data}, {16'h0, UNDRIVEN});
    hostRead(A_ADDR, 16'h0000);
    hostRead(A_STAT, 16'h0000);

    // RAM write/read with auto-increment
    hostWrite(A_ADDR, 16'h1000);
    hostWrite(A_DATA, 16'hAAAA);
    hostWrite(A_DATA, 16'h5555);
    hostWrite(A_ADDR, 16'h1000);
    hostRead(A_DATA, 16'hAAAA);
    hostRead(A_DATA, 16'h5555);
    hostRead(A_ADDR, 16'h1004);

    // Inbound mailbox and overrun
    hostWrite(A_MBX, 16'h1234);
    checkOutput("mbx_in_valid after write", {31'h0, mbx_in_valid}, 32'h1);
    checkOutput("mbx_in_data after write", {16'h0, mbx_in_data}, 32'h1234);
    hostWrite(A_MBX, 16'h5678);
    checkOutput("mbx_in_data second write", {16'h0, mbx_in_data}, 32'h5678);
    hostRead(A_STAT, 16'h0006);
    hostRead(A_STAT, 16'h0002);
    @(posedge clk); #1 mbx_in_ack = 1'b1;
    @(posedge clk); #1 mbx_in_ack = 1'b0;
    checkOutput("mbx_in_valid after ack", {31'h0, mbx_in_valid}, 32'h0);

    // Outbound mailbox
    postOut(16'hBEEF);
    checkOutput("mbx_out_full after post", {31'h0, mbx_out_full}, 32'h1);
`ifdef HPI_INTR_EN
    checkOutput("OTG_INT lags full", {31'h0, otg_int}, 32'h0);
    @(posedge clk); #1;
    checkOutput("OTG_INT rises", {31'h0, otg_int}, 32'h1);
`endif
    hostRead(A_STAT, 16'h0001);
    hostRead(A_MBX, 16'hBEEF);
    checkOutput("mbx_out_full after read", {31'h0, mbx_out_full}, 32'h0);
`ifdef HPI_INTR_EN
    checkOutput("OTG_INT falls", {31'h0, otg_int}, 32'h0);
`endif
    hostRead(A_STAT, 16'h0000);

    // Post colliding with a host mailbox read: old word returned, full stays set
    postOut(16'hCAFE);
    @(posedge clk); #1;
    addr = A_MBX; cs_n = 1'b0; rd_n = 1'b0;
    mbx_out_data = 16'hD00D; mbx_out_wr = 1'b1;
    exp_q.push_back(16'hCAFE);
    @(posedge clk); #1 mbx_out_wr = 1'b0;
    @(posedge clk); #1;
    cs_n = 1'b1; rd_n = 1'b1;
    checkOutput("full kept on collision", {31'h0, mbx_out_full}, 32'h1);
    hostRead(A_MBX, 16'hD00D);
    checkOutput("full cleared", {31'h0, mbx_out_full}, 32'h0);

    // Address wrap and RAM index wrap
    hostWrite(A_ADDR, 16'hFFFE);
    hostWrite(A_DATA, 16'h0F0F);
    hostRead(A_ADDR, 16'h0000);
    hostWrite(A_ADDR, 16'h1FFE);
    hostRead(A_DATA, 16'h0F0F);
    hostRead(A_ADDR, 16'h2000);

    // Long read strobe: one access, bus timing
    hostWrite(A_ADDR, 16'h1000);
    @(posedge clk); #1;
    addr = A_DATA; cs_n = 1'b0; rd_n = 1'b0;
    exp_q.push_back(16'hAAAA);
    @(negedge clk);
    checkOutput("bus Z on rd_start", {16'h0, otg_data}, {16'h0, UNDRIVEN});
    repeat (4) begin
      @(negedge clk);
      checkOutput("bus held during long read", {16'h0, otg_data}, 32'hAAAA);
    end
    @(posedge clk); #1;
    cs_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
    checkOutput("bus driven 1 cycle after release", {16'h0, otg_data}, 32'hAAAA);
    @(negedge clk);
    checkOutput("bus Z after release", {16'h0, otg_data}, {16'h0, UNDRIVEN});
    hostRead(A_ADDR, 16'h1002);

    // RD_N and WR_N low together: write only, never driven
    hostWrite(A_ADDR, 16'h0400);
    @(posedge clk); #1;
    addr = A_DATA; host_wdata = 16'h3C3C; host_oe = 1'b1;
    cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0;
    @(posedge clk); #1 host_oe = 1'b0;
    @(negedge clk);
    checkOutput("no drive with WR_N low", {16'h0, otg_data}, {16'h0, UNDRIVEN});
    @(posedge clk); #1;
    cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    hostRead(A_ADDR, 16'h0402);
    hostWrite(A_ADDR, 16'h0400);
    hostRead(A_DATA, 16'h3C3C);

    // HPI soft reset keeps RAM
    hostWrite(A_ADDR, 16'h0000);
    hostWrite(A_DATA, 16'h7E57);
    hostWrite(A_ADDR, 16'h0200);
    hostWrite(A_MBX, 16'h1111);
    checkOutput("valid before soft reset", {31'h0, mbx_in_valid}, 32'h1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    checkOutput("valid after soft reset", {31'h0, mbx_in_valid}, 32'h0);
    checkOutput("mbx_in_data after soft reset", {16'h0, mbx_in_data}, 32'h0);
    hostRead(A_ADDR, 16'h0000);
    hostRead(A_DATA, 16'h7E57);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", exp_q.size(), 32'h0);
  endtask

  initial begin
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
